// File: rtl/vibrometer_pkg.sv
// Shared constants for the vibrometer acquisition path: DataMover S2MM command
// layout, buffer-count limits and log-length clamping.
package vibrometer_pkg;

    localparam int MAX_BUFFER_COUNT = 8;
    localparam int IDX_W            = $clog2(MAX_BUFFER_COUNT);

    // xCACHE, xUSER, RSVD and TAG nibbles sit above ADDR and are always zero
    localparam int   CMD_HDR_W     = 16;
    localparam int   CMD_DSA_W     = 6;
    localparam int   CMD_BTT_W     = 23;
    localparam int   CMD_EXTRA_W   = CMD_HDR_W + 1 + 1 + CMD_DSA_W + 1 + CMD_BTT_W;
    localparam logic CMD_TYPE_INCR = 1'b1;

    function automatic logic [4:0] clamp_log_length(input logic [4:0] lg, input int btt_w);
        logic [4:0] lim;
        lim = 5'(btt_w - 1);
        return (lg > lim) ? lim : lg;
    endfunction

endpackage

// File: rtl/buffer_allocator.sv
// Picks the lowest ring-buffer index that is neither the just-filled buffer
// nor the buffer currently locked by the reader.
module buffer_allocator
    import vibrometer_pkg::*;
#(
    parameter int BUFFER_COUNT = 3
) (
    input  logic [IDX_W-1:0] full_idx_i,
    input  logic             lock_vld_i,
    input  logic [IDX_W-1:0] lock_idx_i,
    output logic [IDX_W-1:0] wr_idx_o
);

    always_comb begin
        logic found;
        found    = 1'b0;
        wr_idx_o = '0;
        for (int i = 0; i < BUFFER_COUNT; i++) begin
            if (!found && (IDX_W'(i) != full_idx_i) &&
                !(lock_vld_i && (IDX_W'(i) == lock_idx_i))) begin
                wr_idx_o = IDX_W'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_buffer_manager.sv
// Ring-buffer manager: issues one S2MM command per frame into a free buffer,
// tracks the last completed buffer and lets a reader lock it.
module multi_buffer_manager
    import vibrometer_pkg::*;
#(
    parameter int MM_ADDR_WIDTH = 32,
    parameter int BUFFER_COUNT  = 3,
    parameter int BTT_WIDTH     = 23
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic                        SM_enable,
    input  logic [4:0]                  SM_log_length,
    input  logic [MM_ADDR_WIDTH-1:0]    SM_base_address,
    input  logic                        SM_request,
    output logic [MM_ADDR_WIDTH-1:0]    SM_read_buffer,
    output logic                        SM_read_valid,
    output logic [15:0]                 SM_overrun_count,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [MM_ADDR_WIDTH+47:0]   M_AXIS_tdata
);

    localparam int CMD_W = MM_ADDR_WIDTH + CMD_EXTRA_W;

    if (BUFFER_COUNT < 3 || BUFFER_COUNT > MAX_BUFFER_COUNT) begin : g_bad_count
        $error("BUFFER_COUNT out of range");
    end

    logic                     en_q;
    logic [4:0]               len_q, len_d;
    logic [MM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [BTT_WIDTH-1:0]     cnt_q, cnt_d, frame_last;
    logic [IDX_W-1:0]         wr_idx_q, wr_idx_d, full_idx_q, full_idx_d;
    logic [IDX_W-1:0]         lock_idx_q, lock_idx_d, alloc_idx;
    logic                     full_vld_q, full_vld_d, lock_vld_q, lock_vld_d;
    logic                     tvalid_q, tvalid_d;
    logic [CMD_W-1:0]         tdata_q, tdata_d;
    logic [15:0]              ovr_q, ovr_d;
    logic [MM_ADDR_WIDTH-1:0] rd_buf_q, rd_buf_d;
    logic                     rise, run, boundary, pending, grant;

    function automatic logic [MM_ADDR_WIDTH-1:0] buf_addr(
        input logic [MM_ADDR_WIDTH-1:0] base,
        input logic [IDX_W-1:0]         idx,
        input logic [4:0]               lg);
        return base + (MM_ADDR_WIDTH'(idx) << lg);
    endfunction

    function automatic logic [CMD_W-1:0] s2mm_cmd(
        input logic [MM_ADDR_WIDTH-1:0] addr,
        input logic [4:0]               lg);
        logic [CMD_BTT_W-1:0] btt;
        btt = CMD_BTT_W'(1) << lg;
        return {{CMD_HDR_W{1'b0}}, addr, 1'b0, 1'b0, {CMD_DSA_W{1'b0}}, CMD_TYPE_INCR, btt};
    endfunction

    // Exclusion uses next-cycle lock state so a same-cycle grant protects the buffer
    buffer_allocator #(.BUFFER_COUNT(BUFFER_COUNT)) u_alloc (
        .full_idx_i (wr_idx_q),
        .lock_vld_i (lock_vld_d),
        .lock_idx_i (lock_idx_d),
        .wr_idx_o   (alloc_idx)
    );

    always_comb begin
        rise       = SM_enable && !en_q;
        run        = SM_enable && en_q;
        frame_last = (BTT_WIDTH'(1) << len_q) - BTT_WIDTH'(1);
        boundary   = run && (cnt_q == frame_last);
        pending    = tvalid_q && !M_AXIS_tready;
        grant      = SM_request && full_vld_q && !lock_vld_q;

        len_d      = rise ? clamp_log_length(SM_log_length, BTT_WIDTH) : len_q;
        base_d     = rise ? SM_base_address : base_q;
        lock_vld_d = SM_request && (lock_vld_q || full_vld_q);
        lock_idx_d = grant ? full_idx_q : lock_idx_q;
        rd_buf_d   = !SM_request ? '0 :
                     grant       ? buf_addr(base_q, full_idx_q, len_q) : rd_buf_q;

        cnt_d      = cnt_q;
        wr_idx_d   = wr_idx_q;
        full_idx_d = full_idx_q;
        full_vld_d = full_vld_q;
        ovr_d      = ovr_q;
        tvalid_d   = pending;
        tdata_d    = tdata_q;

        if (rise) begin
            cnt_d      = '0;
            wr_idx_d   = '0;
            full_vld_d = 1'b0;
            ovr_d      = '0;
            tvalid_d   = 1'b1;
            tdata_d    = s2mm_cmd(SM_base_address, len_d);
        end else if (run) begin
            cnt_d = boundary ? '0 : cnt_q + BTT_WIDTH'(1);
            if (boundary) begin
                if (pending) begin
                    ovr_d = (ovr_q == 16'hFFFF) ? ovr_q : ovr_q + 16'd1;
                end else begin
                    full_idx_d = wr_idx_q;
                    full_vld_d = 1'b1;
                    wr_idx_d   = alloc_idx;
                    tvalid_d   = 1'b1;
                    tdata_d    = s2mm_cmd(buf_addr(base_q, alloc_idx, len_q), len_q);
                end
            end
        end
    end

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            en_q       <= 1'b0;
            len_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            wr_idx_q   <= '0;
            full_idx_q <= '0;
            full_vld_q <= 1'b0;
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            rd_buf_q   <= '0;
            ovr_q      <= '0;
            tvalid_q   <= 1'b0;
            tdata_q    <= '0;
        end else begin
            en_q       <= SM_enable;
            len_q      <= len_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            wr_idx_q   <= wr_idx_d;
            full_idx_q <= full_idx_d;
            full_vld_q <= full_vld_d;
            lock_vld_q <= lock_vld_d;
            lock_idx_q <= lock_idx_d;
            rd_buf_q   <= rd_buf_d;
            ovr_q      <= ovr_d;
            tvalid_q   <= tvalid_d;
            tdata_q    <= tdata_d;
        end
    end

    assign SM_read_buffer   = rd_buf_q;
    assign SM_read_valid    = lock_vld_q;
    assign SM_overrun_count = ovr_q;
    assign M_AXIS_tvalid    = tvalid_q;
    assign M_AXIS_tdata     = tdata_q;

endmodule
